// File: rtl/distribute_one_hot_sched_seq.sv
// Descriptor-driven scheduler feeding a chain of NUM_NODES one-hot distribute switches.
// Optional performance counters are enabled by defining DIST_SCHED_PERF_CNT_EN.
module distribute_one_hot_sched_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_NODES  = 4,
  parameter int unsigned LEN_WIDTH  = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_desc_valid,
  output logic                  o_desc_ready,
  input  logic [NUM_NODES-1:0]  i_desc_mask,
  input  logic [LEN_WIDTH-1:0]  i_desc_len,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_hold,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data_bus,
  output logic [NUM_NODES-1:0]  o_cmd,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_idle
`ifdef DIST_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]           o_beat_cnt,
  output logic [31:0]           o_hold_cnt
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e                r_state;
  logic [NUM_NODES-1:0]  r_mask_mem [FIFO_DEPTH];
  logic [LEN_WIDTH-1:0]  r_len_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [NUM_NODES-1:0]  r_cur_mask;
  logic [LEN_WIDTH-1:0]  r_cur_len;
  logic [LEN_WIDTH-1:0]  r_beat_cnt;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [NUM_NODES-1:0]  r_cmd;
  logic                  r_err;
  logic                  r_last;
  logic [NUM_NODES-1:0]  r_done_pipe;

  logic                  w_push;
  logic                  w_hs;
  logic                  w_last;
  logic                  w_pop;
  logic                  w_fifo_empty;
  logic [NUM_NODES-1:0]  w_head_mask;
  logic [LEN_WIDTH-1:0]  w_head_len;

  assign w_fifo_empty = (r_count == '0);
  assign o_desc_ready = (r_count < CNT_W'(FIFO_DEPTH));
  assign w_push       = i_desc_valid & o_desc_ready;
  assign w_head_mask  = r_mask_mem[r_rd_ptr];
  assign w_head_len   = r_len_mem[r_rd_ptr];

  assign w_hs         = (r_state == StIssue) & i_data_valid & ~i_hold;
  assign w_last       = w_hs & (r_beat_cnt == r_cur_len);
  // Hold freezes the issue side, including pops from IDLE.
  assign w_pop        = ~w_fifo_empty & ~i_hold & ((r_state == StIdle) | w_last);
  assign o_data_ready = w_hs;

  assign o_valid      = r_valid;
  assign o_data_bus   = r_data;
  assign o_cmd        = r_cmd;
  assign o_err        = r_err;
  assign o_done       = r_done_pipe[NUM_NODES-1];
  assign o_idle       = w_fifo_empty & (r_state == StIdle) & ~(|r_done_pipe) & ~r_last & ~r_valid;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mask_mem[r_wr_ptr] <= i_desc_mask;
      r_len_mem[r_wr_ptr]  <= i_desc_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cur_mask  <= '0;
      r_cur_len   <= '0;
      r_beat_cnt  <= '0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_cmd       <= '0;
      r_err       <= 1'b0;
      r_last      <= 1'b0;
      r_done_pipe <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);

      r_valid <= w_hs & (r_cur_mask != '0);
      r_data  <= w_hs ? i_data : '0;
      r_cmd   <= w_hs ? r_cur_mask : '0;
      r_err   <= w_pop & (w_head_mask == '0);

      // r_last lines up with the last beat on o_valid; the pipe mirrors chain latency.
      r_last      <= w_last;
      r_done_pipe <= {r_done_pipe[NUM_NODES-2:0], r_last};

      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_cur_mask <= w_head_mask;
            r_cur_len  <= w_head_len;
            r_beat_cnt <= '0;
            r_state    <= StIssue;
          end
        end
        StIssue: begin
          if (w_last) begin
            if (w_pop) begin
              r_cur_mask <= w_head_mask;
              r_cur_len  <= w_head_len;
              r_beat_cnt <= '0;
            end else begin
              r_state <= StIdle;
            end
          end else if (w_hs) begin
            r_beat_cnt <= r_beat_cnt + LEN_WIDTH'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef DIST_SCHED_PERF_CNT_EN
  logic [31:0] r_perf_beats;
  logic [31:0] r_perf_holds;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_beats <= '0;
      r_perf_holds <= '0;
    end else begin
      if (w_hs && (r_cur_mask != '0))       r_perf_beats <= r_perf_beats + 32'd1;
      if (i_hold && (r_state == StIssue))   r_perf_holds <= r_perf_holds + 32'd1;
    end
  end

  assign o_beat_cnt = r_perf_beats;
  assign o_hold_cnt = r_perf_holds;
`endif

endmodule
